// File: rtl/adxl362_activity_detect_if.sv
// Sample bus from the accelerometer block into the activity detector.
// The bus carries the per-ODR sample strobe, the sample set and the host status-read pulse.
interface adxl362_activity_detect_if #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DATA_WIDTH = 12
);
  logic                           sample_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]   sample_data;
  logic                           status_clear;

  modport master (output sample_valid, output sample_data, output status_clear);
  modport slave  (input  sample_valid, input  sample_data, input  status_clear);
endinterface

// File: rtl/adxl362_activity_detect.sv
// ADXL362 activity/inactivity detector: threshold/timer evaluation, AWAKE/ASLEEP
// state, ACT/INACT status bits and INTMAP-routed interrupt pins.
module adxl362_activity_detect #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned THRESH_WIDTH = 11,
  parameter int unsigned TACT_WIDTH   = 8,
  parameter int unsigned TINACT_WIDTH = 16
) (
  input  logic                       clk_16mhz,
  input  logic                       reset,
  adxl362_activity_detect_if.slave   smp,
  input  logic [THRESH_WIDTH-1:0]    threshold_active,
  input  logic [TACT_WIDTH-1:0]      time_active,
  input  logic [THRESH_WIDTH-1:0]    threshold_inactive,
  input  logic [TINACT_WIDTH-1:0]    time_inactive,
  input  logic [7:0]                 act_inact_ctrl,
  input  logic [7:0]                 intmap1,
  input  logic [7:0]                 intmap2,
  output logic                       act_status,
  output logic                       inact_status,
  output logic                       awake,
  output logic                       int1,
  output logic                       int2
);
  localparam int unsigned MW  = DATA_WIDTH + 1;
  localparam int unsigned AW  = TACT_WIDTH + 1;
  localparam int unsigned IW  = TINACT_WIDTH + 1;

  typedef enum logic {ST_ASLEEP = 1'b0, ST_AWAKE = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_ref [NUM_CH];
  logic                    r_ref_valid;
  logic [TACT_WIDTH-1:0]   r_act_cnt, w_act_cnt_nxt;
  logic [TINACT_WIDTH-1:0] r_inact_cnt, w_inact_cnt_nxt;
  logic                    r_act_status, w_act_status_nxt;
  logic                    r_inact_status, w_inact_status_nxt;
  logic                    r_int1, r_int2;
  logic [3:0]              r_cfg_q;

  logic [MW-1:0]           w_s       [NUM_CH];
  logic [MW-1:0]           w_met_act [NUM_CH];
  logic [MW-1:0]           w_met_inact [NUM_CH];
  logic                    w_act_hit, w_inact_hit;
  logic [3:0]              w_cfg;
  logic                    w_cfg_chg, w_linked, w_loop;
  logic                    w_act_arm, w_inact_arm;
  logic [AW-1:0]           w_act_inc, w_act_tgt;
  logic [IW-1:0]           w_inact_inc, w_inact_tgt;
  logic                    w_act_fire, w_inact_fire, w_act_evt, w_inact_evt;
  logic                    w_unused;

  function automatic logic [MW-1:0] f_abs(input logic [MW-1:0] v);
    return v[MW-1] ? (~v + MW'(1)) : v;
  endfunction

  // Per-channel metrics at DATA_WIDTH+1 bits; referenced metric is 0 until ref is loaded
  always_comb begin
    w_act_hit   = 1'b0;
    w_inact_hit = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_s[ch] = {smp.sample_data[ch*DATA_WIDTH + DATA_WIDTH - 1],
                 smp.sample_data[ch*DATA_WIDTH +: DATA_WIDTH]};
      w_met_act[ch]   = f_abs(w_s[ch]);
      w_met_inact[ch] = f_abs(w_s[ch]);
      if (act_inact_ctrl[1])
        w_met_act[ch] = r_ref_valid ? f_abs(w_s[ch] - {r_ref[ch][DATA_WIDTH-1], r_ref[ch]}) : '0;
      if (act_inact_ctrl[3])
        w_met_inact[ch] = r_ref_valid ? f_abs(w_s[ch] - {r_ref[ch][DATA_WIDTH-1], r_ref[ch]}) : '0;
      if (w_met_act[ch] > MW'(threshold_active))
        w_act_hit = 1'b1;
      if (!(w_met_inact[ch] < MW'(threshold_inactive)))
        w_inact_hit = 1'b0;
    end
  end

  assign w_cfg     = {act_inact_ctrl[5:4], act_inact_ctrl[2], act_inact_ctrl[0]};
  assign w_cfg_chg = (w_cfg != r_cfg_q);
  assign w_linked  = (act_inact_ctrl[5:4] == 2'b01) || (act_inact_ctrl[5:4] == 2'b11);
  assign w_loop    = (act_inact_ctrl[5:4] == 2'b11);

  assign w_act_arm   = act_inact_ctrl[0] && (!w_linked || (r_state == ST_ASLEEP));
  assign w_inact_arm = act_inact_ctrl[2] && (!w_linked || (r_state == ST_AWAKE));

  assign w_act_inc   = {1'b0, r_act_cnt} + AW'(1);
  assign w_act_tgt   = (time_active == '0) ? AW'(1) : {1'b0, time_active};
  assign w_inact_inc = {1'b0, r_inact_cnt} + IW'(1);
  assign w_inact_tgt = (time_inactive == '0) ? IW'(1) : {1'b0, time_inactive};

  assign w_act_fire   = smp.sample_valid && w_act_arm && w_act_hit && (w_act_inc >= w_act_tgt);
  assign w_inact_fire = smp.sample_valid && w_inact_arm && w_inact_hit && (w_inact_inc >= w_inact_tgt);
  // Activity takes precedence when both fire on the same sample
  assign w_act_evt    = w_act_fire;
  assign w_inact_evt  = w_inact_fire && !w_act_fire;

  // Next-state, counters and status
  always_comb begin
    w_state_nxt        = r_state;
    w_act_cnt_nxt      = r_act_cnt;
    w_inact_cnt_nxt    = r_inact_cnt;
    w_act_status_nxt   = r_act_status;
    w_inact_status_nxt = r_inact_status;

    if (w_act_evt)
      w_state_nxt = ST_AWAKE;
    else if (w_inact_evt)
      w_state_nxt = ST_ASLEEP;

    if (w_cfg_chg) begin
      w_act_cnt_nxt   = '0;
      w_inact_cnt_nxt = '0;
    end else begin
      if (!w_act_arm)
        w_act_cnt_nxt = '0;
      else if (smp.sample_valid)
        w_act_cnt_nxt = (w_act_hit && !w_act_fire) ? w_act_inc[TACT_WIDTH-1:0] : '0;
      if (!w_inact_arm)
        w_inact_cnt_nxt = '0;
      else if (smp.sample_valid)
        w_inact_cnt_nxt = (w_inact_hit && !w_inact_fire) ? w_inact_inc[TINACT_WIDTH-1:0] : '0;
    end

    if (smp.status_clear && !w_loop) begin
      w_act_status_nxt   = 1'b0;
      w_inact_status_nxt = 1'b0;
    end
    if (w_act_evt) begin
      w_act_status_nxt = 1'b1;
      if (w_linked || smp.status_clear)
        w_inact_status_nxt = 1'b0;
    end
    if (w_inact_evt) begin
      w_inact_status_nxt = 1'b1;
      if (w_linked || smp.status_clear)
        w_act_status_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      r_state        <= ST_AWAKE;
      r_act_cnt      <= '0;
      r_inact_cnt    <= '0;
      r_act_status   <= 1'b0;
      r_inact_status <= 1'b0;
      r_ref_valid    <= 1'b0;
      r_cfg_q        <= w_cfg;
      r_int1         <= intmap1[6] ^ intmap1[7];
      r_int2         <= intmap2[6] ^ intmap2[7];
      for (int ch = 0; ch < NUM_CH; ch++)
        r_ref[ch] <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_act_cnt      <= w_act_cnt_nxt;
      r_inact_cnt    <= w_inact_cnt_nxt;
      r_act_status   <= w_act_status_nxt;
      r_inact_status <= w_inact_status_nxt;
      r_cfg_q        <= w_cfg;
      r_int1 <= (|(intmap1[6:4] & {r_state == ST_AWAKE, r_inact_status, r_act_status})) ^ intmap1[7];
      r_int2 <= (|(intmap2[6:4] & {r_state == ST_AWAKE, r_inact_status, r_act_status})) ^ intmap2[7];
      // Reference tracks the first sample and every sample that fires an event
      if (smp.sample_valid && (!r_ref_valid || w_act_evt || w_inact_evt)) begin
        r_ref_valid <= 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++)
          r_ref[ch] <= smp.sample_data[ch*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign act_status   = r_act_status;
  assign inact_status = r_inact_status;
  assign awake        = (r_state == ST_AWAKE);
  assign int1         = r_int1;
  assign int2         = r_int2;

  assign w_unused = ^{act_inact_ctrl[7:6], intmap1[3:0], intmap2[3:0]};
endmodule

// File: tb/tb_adxl362_activity_detect.sv
// Directed bench for adxl362_activity_detect: default/linked/loop sequencing,
// referenced mode, interrupt routing and reset behaviour.
module tb_adxl362_activity_detect;
  localparam int unsigned NUM_CH       = 3;
  localparam int unsigned DATA_WIDTH   = 12;
  localparam int unsigned THRESH_WIDTH = 11;
  localparam int unsigned TACT_WIDTH   = 8;
  localparam int unsigned TINACT_WIDTH = 16;

  logic                    clk_16mhz = 1'b0;
  logic                    reset;
  logic [THRESH_WIDTH-1:0] threshold_active, threshold_inactive;
  logic [TACT_WIDTH-1:0]   time_active;
  logic [TINACT_WIDTH-1:0] time_inactive;
  logic [7:0]              act_inact_ctrl, intmap1, intmap2;
  logic                    act_status, inact_status, awake, int1, int2;

  int n_checks = 0;
  int n_fail   = 0;

  adxl362_activity_detect_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  adxl362_activity_detect #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .THRESH_WIDTH(THRESH_WIDTH),
    .TACT_WIDTH(TACT_WIDTH), .TINACT_WIDTH(TINACT_WIDTH)
  ) dut (
    .clk_16mhz(clk_16mhz), .reset(reset), .smp(bus),
    .threshold_active(threshold_active), .time_active(time_active),
    .threshold_inactive(threshold_inactive), .time_inactive(time_inactive),
    .act_inact_ctrl(act_inact_ctrl), .intmap1(intmap1), .intmap2(intmap2),
    .act_status(act_status), .inact_status(inact_status), .awake(awake),
    .int1(int1), .int2(int2)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_16mhz);
  endtask

  // One-cycle sample strobe; returns on the negedge where the update is visible
  task automatic strobe(input int x, input int y, input int z);
    @(negedge clk_16mhz);
    bus.sample_valid = 1'b1;
    bus.sample_data  = {12'(z), 12'(y), 12'(x)};
    @(negedge clk_16mhz);
    bus.sample_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk_16mhz);
    bus.status_clear = 1'b1;
    @(negedge clk_16mhz);
    bus.status_clear = 1'b0;
  endtask

  task automatic set_ctrl(input logic [7:0] v);
    @(negedge clk_16mhz);
    act_inact_ctrl = v;
    cyc(2);
  endtask

  task automatic do_reset(input logic with_sample);
    @(negedge clk_16mhz);
    reset = 1'b1;
    bus.sample_valid = with_sample;
    bus.sample_data  = {12'(0), 12'(0), 12'(101)};
    @(negedge clk_16mhz);
    reset = 1'b0;
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.sample_valid   = 1'b0;
    bus.sample_data    = '0;
    bus.status_clear   = 1'b0;
    threshold_active   = 11'd100;
    time_active        = 8'd3;
    threshold_inactive = 11'd50;
    time_inactive      = 16'd2;
    act_inact_ctrl     = 8'h01;
    intmap1            = 8'h90;
    intmap2            = 8'h40;
    cyc(2);
    reset = 1'b0;

    // Reset state
    check("rst_act", act_status, 1'b0);
    check("rst_inact", inact_status, 1'b0);
    check("rst_awake", awake, 1'b1);
    check("rst_int1", int1, 1'b1);
    check("rst_int2", int2, 1'b1);

    // Default absolute: threshold is strict, 3 consecutive hits required
    strobe(100, 0, 0); strobe(100, 0, 0); strobe(100, 0, 0);
    check("eq_thr_no_act", act_status, 1'b0);
    strobe(101, 0, 0); strobe(101, 0, 0);
    check("two_hits_no_act", act_status, 1'b0);
    strobe(101, 0, 0);
    check("third_hit_act", act_status, 1'b1);
    check("int1_lag", int1, 1'b1);
    cyc(1);
    check("int1_low", int1, 1'b0);
    clr_pulse();
    check("clr_act", act_status, 1'b0);
    check("int1_clr_lag", int1, 1'b0);
    cyc(1);
    check("int1_high", int1, 1'b1);

    // Miss in the middle restarts the count
    strobe(101, 0, 0); strobe(101, 0, 0); strobe(0, 0, 0);
    strobe(101, 0, 0); strobe(101, 0, 0);
    check("gap_no_act", act_status, 1'b0);
    strobe(101, 0, 0);
    check("gap_act", act_status, 1'b1);

    // Reset mid-count with a coincident strobe
    strobe(101, 0, 0); strobe(101, 0, 0);
    do_reset(1'b1);
    check("midrst_act", act_status, 1'b0);
    check("midrst_int1", int1, 1'b1);
    strobe(101, 0, 0); strobe(101, 0, 0);
    check("midrst_two_hits", act_status, 1'b0);
    strobe(101, 0, 0);
    check("midrst_third", act_status, 1'b1);

    // Linked mode
    time_active = 8'd1;
    set_ctrl(8'h15);
    clr_pulse();
    check("lnk_clr", act_status, 1'b0);
    strobe(200, 10, 10);
    check("lnk_act_unarmed", act_status, 1'b0);
    strobe(10, 10, 10);
    check("lnk_inact_one", inact_status, 1'b0);
    strobe(10, 10, 10);
    check("lnk_inact", inact_status, 1'b1);
    check("lnk_asleep", awake, 1'b0);
    check("lnk_int2_lag", int2, 1'b1);
    cyc(1);
    check("lnk_int2_low", int2, 1'b0);
    strobe(200, 10, 10);
    check("lnk_act", act_status, 1'b1);
    check("lnk_inact_clr", inact_status, 1'b0);
    check("lnk_awake", awake, 1'b1);

    // Loop mode ignores status_clear
    set_ctrl(8'h35);
    clr_pulse();
    check("loop_noclr", act_status, 1'b1);
    cyc(1);
    check("loop_int1", int1, 1'b0);
    strobe(10, 10, 10); strobe(10, 10, 10);
    check("loop_inact", inact_status, 1'b1);
    check("loop_act_clr", act_status, 1'b0);
    check("loop_asleep", awake, 1'b0);

    // Referenced activity
    act_inact_ctrl = 8'h03;
    do_reset(1'b0);
    strobe(1000, 0, 0);
    check("ref_first", act_status, 1'b0);
    strobe(1050, 0, 0);
    check("ref_50", act_status, 1'b0);
    strobe(1101, 0, 0);
    check("ref_101", act_status, 1'b1);
    clr_pulse();
    strobe(1150, 0, 0);
    check("ref_reloaded", act_status, 1'b0);
    strobe(1202, 0, 0);
    check("ref_new_hit", act_status, 1'b1);

    // Negative samples in absolute mode
    set_ctrl(8'h01);
    clr_pulse();
    strobe(-100, 0, 0);
    check("neg_eq_thr", act_status, 1'b0);
    strobe(-101, 0, 0);
    check("neg_hit", act_status, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
